// File: rtl/gf2_rref_stream.sv
// Streaming GF(2) row reducer: loads rows, reduces to RREF in place, then streams rows,
// rank, pivot-column mask and RHS inconsistency out.
// state | meaning
// IDLE  | accept input rows; results of previous job held
// SCAN  | priority search for a pivot in the current column
// SWAP  | move the found pivot row up to row index rank
// ELIM  | clear the pivot column in every other active row
// CHECK | evaluate RHS inconsistency over rows >= rank
// OUT   | stream result rows
module gf2_rref_stream #(
  parameter int MAX_ROWS   = 16,
  parameter int MAX_COLS   = 16,
  parameter int MAX_ROWS_W = $clog2(MAX_ROWS + 1),
  parameter int MAX_COLS_W = $clog2(MAX_COLS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MAX_ROWS_W-1:0] rows,
  input  logic [MAX_COLS_W-1:0] cols,
  input  logic                  aug_mode,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAX_COLS-1:0]   in_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MAX_COLS-1:0]   out_row,
  output logic                  out_last,
  output logic                  busy,
  output logic [MAX_ROWS_W-1:0] rank,
  output logic [MAX_COLS-1:0]   pivot_mask,
  output logic                  inconsistent
);

  localparam int RIDX_W = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
  localparam int CIDX_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [MAX_ROWS_W-1:0] ROW_ONE  = 1;
  localparam logic [MAX_COLS_W-1:0] COL_ONE  = 1;
  localparam logic [RIDX_W-1:0]     RIDX_ONE = 1;
  localparam logic [CIDX_W-1:0]     CIDX_ONE = 1;

  typedef enum logic [2:0] {IDLE, SCAN, SWAP, ELIM, CHECK, OUT} state_t;
  state_t state, state_nxt;

  logic [MAX_COLS-1:0]   m [MAX_ROWS];
  logic [RIDX_W-1:0]     load_cnt, out_idx, piv, pivot_row, rank_idx;
  logic [CIDX_W-1:0]     col, rhs_idx;
  logic [MAX_ROWS_W-1:0] rank_q, rows_m1;
  logic [MAX_COLS_W-1:0] last_col;
  logic [MAX_COLS-1:0]   mask_q, col_mask;
  logic                  incons_q, cfg_ok, accept, load_last, found, col_last;
  logic                  elim_last, rhs_any, out_fire, out_at_last;

  assign rows_m1     = rows - ROW_ONE;
  assign last_col    = cols - COL_ONE - MAX_COLS_W'(aug_mode);
  assign rank_idx    = RIDX_W'(rank_q);
  assign rhs_idx     = CIDX_W'(cols - COL_ONE);
  assign cfg_ok      = (rows >= ROW_ONE) && (rows <= MAX_ROWS_W'(MAX_ROWS)) &&
                       (cols >= COL_ONE) && (cols <= MAX_COLS_W'(MAX_COLS));
  assign in_ready    = rst_n && (state == IDLE) && cfg_ok && !abort;
  assign accept      = in_valid && in_ready;
  assign load_last   = MAX_ROWS_W'(load_cnt) == rows_m1;
  assign col_last    = MAX_COLS_W'(col) == last_col;
  assign elim_last   = col_last || ((rank_q + ROW_ONE) == rows);
  assign out_at_last = MAX_ROWS_W'(out_idx) == rows_m1;

  assign out_valid    = (state == OUT);
  assign out_row      = m[out_idx];
  assign out_last     = out_valid && out_at_last;
  assign out_fire     = out_valid && out_ready;
  assign busy         = (state != IDLE);
  assign rank         = rank_q;
  assign pivot_mask   = mask_q;
  assign inconsistent = incons_q;

  // Descending scan so the lowest qualifying row index wins.
  always_comb begin
    found     = 1'b0;
    pivot_row = '0;
    rhs_any   = 1'b0;
    col_mask  = '0;
    for (int r = MAX_ROWS - 1; r >= 0; r--) begin
      if (r >= int'(rank_q) && r < int'(rows) && m[r][col]) begin
        found     = 1'b1;
        pivot_row = RIDX_W'(r);
      end
    end
    for (int r = 0; r < MAX_ROWS; r++) begin
      if (r >= int'(rank_q) && r < int'(rows) && m[r][rhs_idx]) rhs_any = 1'b1;
    end
    for (int c = 0; c < MAX_COLS; c++) col_mask[c] = (c < int'(cols));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept && load_last)
               state_nxt = (aug_mode && cols == COL_ONE) ? CHECK : SCAN;
      SCAN:  if (!found)                state_nxt = col_last ? CHECK : SCAN;
             else if (pivot_row == rank_idx) state_nxt = ELIM;
             else                       state_nxt = SWAP;
      SWAP:  state_nxt = ELIM;
      ELIM:  state_nxt = elim_last ? CHECK : SCAN;
      CHECK: state_nxt = OUT;
      OUT:   if (out_fire && out_at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < MAX_ROWS; r++) m[r] <= '0;
      load_cnt <= '0;
      out_idx  <= '0;
      piv      <= '0;
      col      <= '0;
      rank_q   <= '0;
      mask_q   <= '0;
      incons_q <= 1'b0;
    end else if (abort) begin
      load_cnt <= '0;
      out_idx  <= '0;
      col      <= '0;
      rank_q   <= '0;
      mask_q   <= '0;
      incons_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (load_cnt == '0) begin
            for (int r = 0; r < MAX_ROWS; r++) if (r >= int'(rows)) m[r] <= '0;
            rank_q   <= '0;
            mask_q   <= '0;
            incons_q <= 1'b0;
          end
          m[load_cnt] <= in_row & col_mask;
          load_cnt    <= load_last ? '0 : load_cnt + RIDX_ONE;
          col         <= '0;
        end
        SCAN: begin
          piv <= pivot_row;
          if (!found && !col_last) col <= col + CIDX_ONE;
        end
        SWAP: begin
          m[piv]      <= m[rank_idx];
          m[rank_idx] <= m[piv];
        end
        ELIM: begin
          for (int r = 0; r < MAX_ROWS; r++) begin
            if (r != int'(rank_q) && r < int'(rows) && m[r][col]) m[r] <= m[r] ^ m[rank_idx];
          end
          mask_q[col] <= 1'b1;
          rank_q      <= rank_q + ROW_ONE;
          if (!elim_last) col <= col + CIDX_ONE;
        end
        CHECK: begin
          incons_q <= aug_mode && rhs_any;
          out_idx  <= '0;
        end
        OUT: if (out_fire) out_idx <= out_at_last ? '0 : out_idx + RIDX_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_rref_stream.sv
// Directed bench for gf2_rref_stream: hand-reduced matrices, latency, backpressure,
// abort and illegal configurations.
module tb_gf2_rref_stream;
  localparam int MR = 16;
  localparam int MC = 16;
  localparam int RW = $clog2(MR + 1);
  localparam int CW = $clog2(MC + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] rows = RW'(3);
  logic [CW-1:0] cols = CW'(3);
  logic          aug_mode = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MC-1:0] in_row = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [MC-1:0] out_row;
  logic          out_last;
  logic          busy;
  logic [RW-1:0] rank;
  logic [MC-1:0] pivot_mask;
  logic          inconsistent;

  gf2_rref_stream #(.MAX_ROWS(MR), .MAX_COLS(MC)) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols), .aug_mode(aug_mode),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last), .busy(busy), .rank(rank), .pivot_mask(pivot_mask),
    .inconsistent(inconsistent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [MC-1:0] got_row [4];
  logic          got_last [4];

  task automatic load_job(input int n, input int c, input logic a,
                          input logic [MC-1:0] r0, input logic [MC-1:0] r1,
                          input logic [MC-1:0] r2);
    logic [MC-1:0] d [3];
    d[0] = r0; d[1] = r1; d[2] = r2;
    rows = RW'(n); cols = CW'(c); aug_mode = a;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_row   = d[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_row   = '0;
  endtask

  // lat counts the cycle right after the last accept as 1.
  task automatic wait_out();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic collect(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (out_valid !== 1'b1 && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      got_row[i]  = out_row;
      got_last[i] = out_last;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got valid=%b last=%b busy=%b expected 0 0 0", out_valid, out_last, busy); end
    checks++; if (rank !== '0 || pivot_mask !== '0 || inconsistent !== 1'b0) begin
      errors++; $display("FAIL reset_results: got rank=%0d mask=%h inc=%b expected 0 0 0", rank, pivot_mask, inconsistent); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", in_ready); end
  endtask

  task automatic test_identity();
    logic [MC-1:0] e [3];
    e[0] = 16'h1; e[1] = 16'h2; e[2] = 16'h4;
    load_job(3, 3, 1'b0, 16'h1, 16'h2, 16'h4);
    wait_out();
    checks++; if (lat !== 8) begin errors++; $display("FAIL identity_latency: got %0d expected 8", lat); end
    checks++; if (rank !== RW'(3) || pivot_mask !== 16'h7 || inconsistent !== 1'b0) begin
      errors++; $display("FAIL identity_results: got rank=%0d mask=%h inc=%b expected 3 0007 0", rank, pivot_mask, inconsistent); end
    collect(3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_row[i] !== e[i] || got_last[i] !== (i == 2)) begin
        errors++; $display("FAIL identity_row%0d: got %h last=%b expected %h last=%b", i, got_row[i], got_last[i], e[i], (i == 2)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL identity_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_aug_solve();
    load_job(2, 3, 1'b1, 16'h7, 16'h6, 16'h0);
    wait_out();
    checks++; if (lat !== 6) begin errors++; $display("FAIL aug_latency: got %0d expected 6", lat); end
    checks++; if (rank !== RW'(2) || pivot_mask !== 16'h3 || inconsistent !== 1'b0) begin
      errors++; $display("FAIL aug_results: got rank=%0d mask=%h inc=%b expected 2 0003 0", rank, pivot_mask, inconsistent); end
    collect(2);
    checks++; if (got_row[0] !== 16'h1 || got_row[1] !== 16'h6 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
      errors++; $display("FAIL aug_rows: got %h %h last=%b%b expected 0001 0006 last=01", got_row[0], got_row[1], got_last[0], got_last[1]); end
  endtask

  // Bit 5 of the first row lies beyond cols and must be dropped on load.
  task automatic test_inconsistent();
    load_job(2, 3, 1'b1, 16'h23, 16'h7, 16'h0);
    wait_out();
    checks++; if (lat !== 5) begin errors++; $display("FAIL incons_latency: got %0d expected 5", lat); end
    checks++; if (rank !== RW'(1) || pivot_mask !== 16'h1 || inconsistent !== 1'b1) begin
      errors++; $display("FAIL incons_results: got rank=%0d mask=%h inc=%b expected 1 0001 1", rank, pivot_mask, inconsistent); end
    collect(2);
    checks++; if (got_row[0] !== 16'h3 || got_row[1] !== 16'h4) begin
      errors++; $display("FAIL incons_rows: got %h %h expected 0003 0004", got_row[0], got_row[1]); end
  endtask

  task automatic test_rhs_only();
    load_job(1, 1, 1'b1, 16'h1, 16'h0, 16'h0);
    wait_out();
    checks++; if (lat !== 2) begin errors++; $display("FAIL rhs_only_latency: got %0d expected 2", lat); end
    checks++; if (rank !== '0 || pivot_mask !== '0 || inconsistent !== 1'b1) begin
      errors++; $display("FAIL rhs_only_results: got rank=%0d mask=%h inc=%b expected 0 0000 1", rank, pivot_mask, inconsistent); end
    collect(1);
    checks++; if (got_row[0] !== 16'h1 || got_last[0] !== 1'b1) begin
      errors++; $display("FAIL rhs_only_row: got %h last=%b expected 0001 last=1", got_row[0], got_last[0]); end
  endtask

  // Swaps on col0 and col1 show up as one extra cycle each: 1 + 3 + 3 + 2 + 1.
  task automatic test_swap();
    load_job(3, 3, 1'b0, 16'h4, 16'h1, 16'h2);
    wait_out();
    checks++; if (lat !== 10) begin errors++; $display("FAIL swap_latency: got %0d expected 10", lat); end
    checks++; if (rank !== RW'(3) || pivot_mask !== 16'h7) begin
      errors++; $display("FAIL swap_results: got rank=%0d mask=%h expected 3 0007", rank, pivot_mask); end
    collect(3);
    checks++; if (got_row[0] !== 16'h1 || got_row[1] !== 16'h2 || got_row[2] !== 16'h4) begin
      errors++; $display("FAIL swap_rows: got %h %h %h expected 0001 0002 0004", got_row[0], got_row[1], got_row[2]); end
  endtask

  // Rows 011,110,111 reduce to the identity with multi-row elimination.
  task automatic test_backpressure();
    load_job(3, 3, 1'b0, 16'h3, 16'h6, 16'h7);
    wait_out();
    checks++; if (out_valid !== 1'b1 || out_row !== 16'h1 || out_last !== 1'b0) begin
      errors++; $display("FAIL bp_row0: got v=%b %h last=%b expected 1 0001 0", out_valid, out_row, out_last); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out_row !== 16'h2 || out_last !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b %h last=%b expected 1 0002 0", k, out_valid, out_row, out_last); end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b1 || out_row !== 16'h2 || out_last !== 1'b0) begin
      errors++; $display("FAIL bp_release: got v=%b %h last=%b expected 1 0002 0", out_valid, out_row, out_last); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_row !== 16'h4 || out_last !== 1'b1) begin
      errors++; $display("FAIL bp_row2: got v=%b %h last=%b expected 1 0004 1", out_valid, out_row, out_last); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_done: got v=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  task automatic test_abort();
    load_job(3, 3, 1'b0, 16'h1, 16'h2, 16'h4);
    @(posedge clk); #1;
    abort = 1'b1;
    in_valid = 1'b1;
    in_row = 16'h5;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", in_ready); end
    abort = 1'b0;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || rank !== '0 || pivot_mask !== '0) begin
      errors++; $display("FAIL abort_state: got busy=%b v=%b rank=%0d mask=%h expected 0 0 0 0000", busy, out_valid, rank, pivot_mask); end
    rows = RW'(2); cols = CW'(3); aug_mode = 1'b1;
    in_valid = 1'b1;
    in_row = 16'h5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    load_job(2, 3, 1'b1, 16'h7, 16'h6, 16'h0);
    wait_out();
    checks++; if (lat !== 6 || rank !== RW'(2) || pivot_mask !== 16'h3 || inconsistent !== 1'b0) begin
      errors++; $display("FAIL abort_rerun: got lat=%0d rank=%0d mask=%h inc=%b expected 6 2 0003 0", lat, rank, pivot_mask, inconsistent); end
    collect(2);
    checks++; if (got_row[0] !== 16'h1 || got_row[1] !== 16'h6) begin
      errors++; $display("FAIL abort_rerun_rows: got %h %h expected 0001 0006", got_row[0], got_row[1]); end
  endtask

  task automatic test_illegal();
    rows = '0; cols = CW'(3); aug_mode = 1'b0;
    in_valid = 1'b1;
    in_row = 16'h1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rows0_ready%0d: got %b expected 0", k, in_ready); end
      @(posedge clk); #1;
    end
    rows = RW'(3); cols = '0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cols0_ready: got %b expected 0", in_ready); end
    rows = RW'(17); cols = CW'(3);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rows17_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy: got %b expected 0", busy); end
    rows = RW'(3);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL legal_ready: got %b expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_aug_solve();
    test_inconsistent();
    test_rhs_only();
    test_swap();
    test_backpressure();
    test_abort();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf2_rref_stream.md
Name: gf2_rref_stream

Overview:
Parametrised successor to the in-place GF(2) row reducer. Rows arrive over a valid/ready stream. The block reduces the matrix to reduced row-echelon form using a single-cycle priority pivot search, then streams the result rows out. It also reports rank, pivot-column mask and, in augmented mode, system inconsistency. It sits between the puzzle-row parser and the solution enumerator.

Parameters:
MAX_ROWS, 16, maximum matrix rows (>=1)
MAX_COLS, 16, maximum matrix columns including the RHS column (>=1)
MAX_ROWS_W, derived $clog2(MAX_ROWS+1), width of row counts
MAX_COLS_W, derived $clog2(MAX_COLS+1), width of column counts

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
rows  in  MAX_ROWS_W  active row count; held stable from first accepted row until last output handshake
cols  in  MAX_COLS_W  active column count; same stability rule as rows
aug_mode  in  1  1: column cols-1 is the RHS and is never a pivot column; same stability rule
abort  in  1  synchronous return to IDLE
in_valid  in  1  input row valid
in_ready  out  1  block can accept a row
in_row  in  MAX_COLS  row data; bit c = column c; bits >= cols are ignored and forced to 0
out_valid  out  1  result row valid
out_ready  in  1  consumer accepts result row
out_row  out  MAX_COLS  RREF row, rows 0..rows-1 in order
out_last  out  1  high with out_valid on row rows-1
busy  out  1  high in any state other than IDLE
rank  out  MAX_ROWS_W  number of pivots found
pivot_mask  out  MAX_COLS  bit c set if column c holds a pivot
inconsistent  out  1  aug_mode and some row r >= rank has RHS bit set

Behaviour:
- Reset: state=IDLE; in_ready=0 during the reset cycle; out_valid=0, out_last=0, busy=0, rank=0, pivot_mask=0, inconsistent=0, matrix storage=0.
- in_ready = (state==IDLE) && 1<=rows<=MAX_ROWS && 1<=cols<=MAX_COLS && !abort. For an illegal configuration the block stays in IDLE and accepts nothing.
- States: IDLE, SCAN, SWAP, ELIM, CHECK, OUT.
- IDLE: each in_valid&&in_ready stores the row at index load_cnt, then load_cnt++. The first accept of a job clears rank, pivot_mask, inconsistent and all rows >= rows. Accepting row rows-1 moves the state to SCAN next cycle, with col=0, rank=0.
- last_col = cols-1-aug_mode. If aug_mode && cols==1 there are no pivot columns and the state goes IDLE -> CHECK directly.
- SCAN (1 cycle): p = lowest r in [rank, rows-1] with m[r][col]=1.
  - No p: if col==last_col -> CHECK, else col++ and stay in SCAN.
  - p==rank -> ELIM.
  - Otherwise latch p -> SWAP.
- SWAP (1 cycle): exchange m[p] and m[rank] -> ELIM.
- ELIM (1 cycle):
  - Every r != rank in [0, rows-1] with m[r][col]=1 gets m[r] ^= m[rank].
  - pivot_mask[col] <= 1 and rank++.
  - If col==last_col or rank+1==rows -> CHECK; else col++ -> SCAN.
- CHECK (1 cycle): inconsistent <= aug_mode && OR over r in [rank, rows-1] of m[r][cols-1]. Then -> OUT with out_idx=0.
- OUT:
  - out_valid=1, out_row=m[out_idx], out_last=(out_idx==rows-1).
  - out_row and out_last are held stable while out_ready=0.
  - A handshake advances out_idx; the handshake on the last row -> IDLE.
  - out_valid is never asserted outside OUT.
- rank, pivot_mask and inconsistent become valid when OUT is entered. They hold until the first accept of the next job.
- Latency from the last input accept to the first out_valid: 1 + (SCAN/SWAP/ELIM cycles) + 1. Per column: no pivot = 1 cycle, pivot in place = 2, pivot needing a swap = 3.
- abort (any state, highest priority after rst_n): next cycle state=IDLE, out_valid=0, load_cnt=0, rank=0, pivot_mask=0, inconsistent=0. Matrix contents are don't-care. An in_valid coinciding with abort is not accepted.
- Width rules: rank never exceeds rows. col and out_idx never exceed MAX_COLS-1 / MAX_ROWS-1, so there is no wrap.

Test Plan:
- Identity, rows=3 cols=3 aug=0, rows 001,010,100: out_valid first high exactly 8 cycles after the last accept; output equals input; rank=3, pivot_mask=0x7, inconsistent=0.
- Augmented solve, rows=2 cols=3 aug=1, rows 111,110: out rows 001,110; rank=2, pivot_mask=0x3, inconsistent=0.
- Inconsistent, rows=2 cols=3 aug=1, rows 011,111: out rows 011,100; rank=1, pivot_mask=0x1, inconsistent=1.
- Swap path, rows=3 cols=3 aug=0, rows 100,001,010: out rows 001,010,100; rank=3. Verify the SWAP state is taken on col0 and col1.
- Backpressure: out_ready low for 5 cycles on row 1 -> out_row and out_last stable, no row skipped or duplicated; out_last only on row rows-1.
- Abort/illegal config: abort asserted during ELIM -> IDLE next cycle, busy=0, rank=0, and a fresh job then completes correctly. rows=0 -> in_ready stays 0.
